// File: rtl/bus_arb_mux_pkg.sv
// Purpose: shared constants and helpers for the arbitrated bus multiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_mux_pkg;

  localparam int BUS_WIDTH_DEFAULT = 64;

  // Width of a channel index for n channels.
  function automatic int sel_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arb_mux_rr_arbiter.sv
// Purpose: round-robin / fixed-priority arbiter with a next-start pointer register.
// Latency: grant is combinational from req/fixed_prio; pointer moves on the next edge.
// Backpressure: pointer advances only when advance is high and something was granted.
//
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   req         - per-channel request vector
//   fixed_prio  - 1: lowest index wins; 0: search upward from the pointer with wrap
//   advance     - the granted word is actually taken this cycle
//   grant       - one-hot grant (all zero when no request)
//   grant_idx   - binary index of the granted channel (0 when no grant)
module rr_arbiter
  import bus_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] req,
  input  logic                fixed_prio,
  input  logic                advance,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx
);

  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic [SEL_W-1:0] base;
  logic [SEL_W-1:0] idx;
  logic             found;

  // Search order starts at base and wraps naturally because CHANNELS is a
  // power of two, so the SEL_W-bit sum truncates to (base + k) mod CHANNELS.
  // The pointer is tracked in both modes so fairness history survives a
  // switch from fixed priority back to round-robin.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    base      = fixed_prio ? '0 : ptr_q;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = base + SEL_W'(k);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = grant_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bus_arb_mux.sv
// Purpose: N-channel valid/ready bus multiplexer with arbitration and a registered output.
// Latency: one cycle from an accepted input word to out_valid.
// Backpressure: while out_valid && !out_ready the output holds and every in_ready is 0.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   in_data/in_valid    - per-channel words and their valids (packed [CHANNELS][WIDTH])
//   in_ready            - per-channel accept strobe, combinational
//   fixed_prio          - 1: fixed priority, 0: round-robin (takes effect same cycle)
//   out_data/out_sel    - registered word and the index of the channel that supplied it
//   out_valid/out_ready - output handshake
module bus_arb_mux
  import bus_mux_pkg::*;
#(
  parameter int WIDTH    = BUS_WIDTH_DEFAULT,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS-1:0][WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  input  logic                           fixed_prio,
  output logic [WIDTH-1:0]               out_data,
  output logic [SEL_W-1:0]               out_sel,
  output logic                           out_valid,
  input  logic                           out_ready
);

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_sel_q, out_sel_d;
  logic                out_valid_q, out_valid_d;

  logic                adv;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                xfer;
  logic [WIDTH-1:0]    sel_data;

  // The output slot can take a new word when it is empty or being drained.
  // Reset also blocks acceptance so no producer thinks its word was taken.
  assign adv = (!out_valid_q || out_ready) && !reset;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        (in_valid),
    .fixed_prio (fixed_prio),
    .advance    (adv),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign in_ready = grant & {CHANNELS{adv}};
  // Grant is a subset of in_valid, so any ready bit means a transfer.
  assign xfer     = |in_ready;

  // One-hot AND-OR select; grant is one-hot so at most one term is non-zero.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_data = sel_data | (in_data[i] & {WIDTH{grant[i]}});
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = sel_data;
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      // Drained with nothing behind it: keep data/sel, just drop valid.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
module tb_bus_arb_mux;

  localparam int W = 16;
  localparam int N = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0][W-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               fixed_prio;
  logic [W-1:0]       out_data;
  logic [1:0]         out_sel;
  logic               out_valid;
  logic               out_ready;

  bus_arb_mux #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fixed_prio (fixed_prio),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock: drive at negedge, capture in_ready just before the edge,
  // return with outputs settled 1 time unit after the rising edge.
  task automatic cyc(input logic [3:0] v, input logic fp, input logic ordy,
                     input logic rst, output logic [3:0] rdy_seen);
    @(negedge clk);
    reset      = rst;
    in_valid   = v;
    fixed_prio = fp;
    out_ready  = ordy;
    #1 rdy_seen = in_ready;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic        fp;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  sel;
    logic [15:0] dat;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] v, input logic fp, input logic ordy,
                     input logic [3:0] rdy, input logic ov, input logic [1:0] sel,
                     input logic [15:0] dat);
    vec_t e;
    e.v = v; e.fp = fp; e.ordy = ordy; e.rdy = rdy; e.ov = ov; e.sel = sel; e.dat = dat;
    tbl.push_back(e);
  endtask

  // Reference model: plain ints, grant found by a modular walk from the start index.
  int          m_ptr;
  bit          m_ov;
  int          m_sel;
  logic [15:0] m_data;

  function automatic int model_grant(input logic [3:0] v, input bit fp, input int ptr);
    int start = fp ? 0 : ptr;
    for (int k = 0; k < N; k++) begin
      int c = (start + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  logic [N-1:0][W-1:0] fixed_words;
  logic [3:0]  rdy;
  logic [15:0] pend_data [N];
  bit          pend_v    [N];

  initial begin
    fixed_words = {16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
    reset = 1'b1; in_valid = '0; fixed_prio = 1'b0; out_ready = 1'b0;
    in_data = fixed_words;
    repeat (2) @(posedge clk);

    // Reset state; requests during reset must not be acknowledged.
    cyc(4'b1111, 1'b0, 1'b0, 1'b1, rdy);
    chk("rst_in_ready", 32'(rdy), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_sel", 32'(out_sel), 32'h0);

    // Idle after reset.
    for (int i = 0; i < 5; i++) add(4'b0000, 0, 1, 4'b0000, 0, 2'd0, 16'h0000);
    // Round-robin, all requesting, sink always ready.
    for (int i = 0; i < 2; i++) begin
      add(4'b1111, 0, 1, 4'b0001, 1, 2'd0, 16'h0123);
      add(4'b1111, 0, 1, 4'b0010, 1, 2'd1, 16'h4567);
      add(4'b1111, 0, 1, 4'b0100, 1, 2'd2, 16'h89AB);
      add(4'b1111, 0, 1, 4'b1000, 1, 2'd3, 16'hCDEF);
    end
    // Fixed priority: channel 1 always wins, pointer ends at 2.
    for (int i = 0; i < 3; i++) add(4'b1110, 1, 1, 4'b0010, 1, 2'd1, 16'h4567);
    // Channel 2 word, then held under backpressure (ptr becomes 3).
    add(4'b0100, 0, 1, 4'b0100, 1, 2'd2, 16'h89AB);
    for (int i = 0; i < 3; i++) add(4'b1111, 0, 0, 4'b0000, 1, 2'd2, 16'h89AB);
    // Release with no requests: valid drops, data/sel kept.
    add(4'b0000, 0, 1, 4'b0000, 0, 2'd2, 16'h89AB);
    // Next round-robin grant is channel 3.
    add(4'b1111, 0, 1, 4'b1000, 1, 2'd3, 16'hCDEF);
    // Bring ptr to 3 again, then sparse request on channel 0 (wrap).
    add(4'b0100, 0, 1, 4'b0100, 1, 2'd2, 16'h89AB);
    add(4'b0001, 0, 1, 4'b0001, 1, 2'd0, 16'h0123);
    add(4'b0001, 0, 1, 4'b0001, 1, 2'd0, 16'h0123);
    // ptr must now be 1.
    add(4'b1111, 0, 1, 4'b0010, 1, 2'd1, 16'h4567);
    // Empty slot accepts even with out_ready low, then holds.
    add(4'b0000, 0, 1, 4'b0000, 0, 2'd1, 16'h4567);
    add(4'b0100, 0, 0, 4'b0100, 1, 2'd2, 16'h89AB);
    add(4'b0000, 0, 0, 4'b0000, 1, 2'd2, 16'h89AB);

    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].fp, tbl[i].ordy, 1'b0, rdy);
      chk($sformatf("vec%0d_in_ready", i), 32'(rdy), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("vec%0d_out_sel", i), 32'(out_sel), 32'(tbl[i].sel));
      chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].dat));
    end

    // Reset while a word is held: word discarded, pointer back to 0.
    cyc(4'b1111, 1'b0, 1'b0, 1'b1, rdy);
    chk("midrst_in_ready", 32'(rdy), 32'h0);
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_out_sel", 32'(out_sel), 32'h0);
    chk("midrst_out_data", 32'(out_data), 32'h0);
    cyc(4'b1111, 1'b0, 1'b1, 1'b0, rdy);
    chk("postrst_in_ready", 32'(rdy), 32'b0001);
    chk("postrst_out_sel", 32'(out_sel), 32'h0);
    chk("postrst_out_data", 32'(out_data), 32'h0123);
    cyc(4'b1111, 1'b0, 1'b1, 1'b0, rdy);
    chk("postrst2_out_sel", 32'(out_sel), 32'h1);

    // Randomised phase against the reference model.
    cyc(4'b0000, 1'b0, 1'b0, 1'b1, rdy);
    m_ptr = 0; m_ov = 0; m_sel = 0; m_data = '0;
    for (int c = 0; c < N; c++) begin
      pend_v[c] = 0; pend_data[c] = '0;
    end
    for (int t = 0; t < 3000; t++) begin
      logic [3:0] v;
      bit         fp, ordy, adv;
      int         g;
      logic [3:0] exp_rdy;
      for (int c = 0; c < N; c++) begin
        if (!pend_v[c] && ($urandom_range(0, 2) != 0)) begin
          pend_v[c]    = 1;
          pend_data[c] = 16'($urandom);
        end
        v[c]       = pend_v[c];
        in_data[c] = pend_data[c];
      end
      fp   = ($urandom_range(0, 3) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      adv  = !m_ov || ordy;
      g    = adv ? model_grant(v, fp, m_ptr) : -1;
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;

      cyc(v, fp, ordy, 1'b0, rdy);

      if (g >= 0) begin
        m_data = pend_data[g];
        m_sel  = g;
        m_ov   = 1;
        m_ptr  = (g + 1) % N;
        pend_v[g] = 0;
      end else if (ordy) begin
        m_ov = 0;
      end
      chk("rand_in_ready", 32'(rdy), 32'(exp_rdy));
      chk("rand_out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk("rand_out_sel", 32'(out_sel), 32'(m_sel));
        chk("rand_out_data", 32'(out_data), 32'(m_data));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arb_mux.md
# bus_arb_mux

Parametrised N-channel bus multiplexer with built-in arbitration, valid/ready handshakes and a registered output stage. Up to CHANNELS producers (e.g. register-file write-back sources, memory/ALU result ports) compete for one downstream WIDTH-bit bus. Selection is round-robin or fixed-priority, chosen at run time. It replaces hand-wired select trees wherever sources are not mutually exclusive or the sink can stall.

## Interface
- WIDTH, 64, data bus width in bits (≥1)
- CHANNELS, 4, number of input channels (power of two, ≥2)
- SEL_W, $clog2(CHANNELS), derived; width of channel index

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_data  input  [CHANNELS-1:0][WIDTH-1:0]  per-channel data, packed array
- in_valid  input  [CHANNELS-1:0]  channel i offers in_data[i]
- in_ready  output  [CHANNELS-1:0]  channel i's word is taken this cycle when in_valid[i] is also high
- fixed_prio  input  1  1 = fixed priority (lowest index wins); 0 = round-robin
- out_data  output  WIDTH  registered selected word
- out_sel  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  out_data/out_sel hold a word
- out_ready  input  1  sink accepts the word this cycle

## Operation
- Request vector: req = in_valid.
- Advance condition: adv = !out_valid || out_ready.
- Grant, fixed_prio=1: lowest-index set bit of req.
- Grant, fixed_prio=0: first set bit of req, searching from ptr upward with wrap (ptr, ptr+1, …, CHANNELS-1, 0, …).
- Grant is one-hot or zero. in_ready = grant & {CHANNELS{adv}}.
- Transfer on channel i: in_valid[i] && in_ready[i]. At most one per cycle.
- On transfer, next edge: out_data ← in_data[i]; out_sel ← i; out_valid ← 1.
- Round-robin pointer update, on transfer only: ptr ← (i+1) mod CHANNELS, with wrap CHANNELS-1 → 0. The pointer is updated in both modes, so switching modes keeps fairness history.
- If out_ready && out_valid and there is no transfer: out_valid ← 0. out_data/out_sel keep their last value.
- If out_valid && !out_ready: output is held stable and all in_ready are 0.
- No requests: grant 0, ptr unchanged.
- fixed_prio is sampled combinationally and takes effect in the same cycle; no state change on toggle.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready=0 during reset cycles.
- Latency: one cycle from accepted input to out_valid.
- Throughput: one word per cycle when out_ready is held high.
- in_ready is combinational from in_valid, fixed_prio, out_valid and out_ready. No path from in_ready back to in_valid is permitted, which avoids loops.
- in_valid must not depend combinationally on in_ready. A producer holds in_data/in_valid until it is accepted.
- Simultaneous sink accept and new transfer: word is replaced in the same edge, and out_valid stays 1.
- Reset mid-operation: a held output word is discarded and the pointer returns to 0. Producers re-offer their words.
- Round-robin guarantee: a continuously requesting channel is granted within CHANNELS transfers.

## Structure
- Shared package bus_mux_pkg holds:
  - default width constant BUS_WIDTH_DEFAULT = 64
  - function sel_width(n) returning $clog2(n)
- Sub-module rr_arbiter (CHANNELS): combinational search and pointer register.
  - Ports: clk, reset, req, fixed_prio, advance, grant (one-hot), grant_idx.
  - Pointer updates only when advance && |grant.
- Top level: data select (one-hot AND-OR over in_data), output register, handshake logic. Roughly 150–250 lines total.

## Test plan
Bench parameters: WIDTH=16, CHANNELS=4. Inputs in_data = {16'hCDEF, 16'h89AB, 16'h4567, 16'h0123} for channels 3..0.

- Reset then all in_valid=0 → out_valid=0, out_data=0, in_ready=4'b0000 for 5 cycles.
- fixed_prio=0, in_valid=4'b1111, out_ready=1 for 8 cycles → out_sel sequence 0,1,2,3,0,1,2,3; out_data 0123,4567,89AB,CDEF repeating; one word per cycle.
- fixed_prio=1, in_valid=4'b1110, out_ready=1 → out_sel stays 1 and out_data=4567 every cycle; channel 3 is never granted.
- Backpressure: one word from channel 2 held with out_ready=0 for 3 cycles → out_data=89AB and out_sel=2 stable; in_ready=0000. Release → next grant is channel 3 (ptr=3).
- Wrap and sparse requests: ptr=3, in_valid=4'b0001 → channel 0 granted and ptr becomes 1. Then in_valid=4'b0001 again → channel 0 granted (wrap search).
- Reset asserted while out_valid=1 and out_ready=0 → next cycle out_valid=0 and out_sel=0. With in_valid=1111 after reset, the first grant is channel 0.
